// File: rtl/tracker_disp_pkg.sv
// Digit codes and 7-segment glyphs shared by the tracker display path.
// Segment order is {g,f,e,d,c,b,a}; a 0 bit lights the segment.
package tracker_disp_pkg;

  localparam logic [4:0] CODE_BLANK      = 5'h10;
  localparam logic [4:0] CODE_UNDERSCORE = 5'h1F;

  localparam logic [6:0] SEG_BLANK      = 7'h7F;
  localparam logic [6:0] SEG_DASH       = 7'b0111111;
  localparam logic [6:0] SEG_UNDERSCORE = 7'b1110111;

  // Entry n holds the glyph for decimal digit n
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational 5-bit digit code to active-low segment pattern.
// Codes outside 0-9, underscore and blank render as a dash.
module seg7_decode
  import tracker_disp_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (code < 5'd10) begin
      seg = SEG_DIGITS[code[3:0]];
    end else if (code == CODE_UNDERSCORE) begin
      seg = SEG_UNDERSCORE;
    end else if (code == CODE_BLANK) begin
      seg = SEG_BLANK;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed 7-segment driver with per-slot blanking gap,
// frame-coherent digit capture and leading-zero blanking.
module seg7_scan_driver
  import tracker_disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic [4:0] bcd3,
  input  logic [4:0] bcd2,
  input  logic [4:0] bcd1,
  input  logic [4:0] bcd0,
  input  logic       si,
  input  logic       blz_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       si_led
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [4:0]       r_shadow [4];
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic             r_si_led;

  logic [4:0] w_bcd [4];
  logic [3:0] w_blank;
  logic [4:0] w_code;
  logic [6:0] w_seg;
  logic       w_slot_end;
  logic       w_frame_end;

  assign w_bcd[3] = bcd3;
  assign w_bcd[2] = bcd2;
  assign w_bcd[1] = bcd1;
  assign w_bcd[0] = bcd0;

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_slot_end && (r_idx == 2'd3);

  // A digit is a leading zero when it and every digit to its left are code 0
  always_comb begin
    w_blank = 4'b0000;
    for (int k = 1; k < 4; k++) begin
      w_blank[k] = blz_en;
      for (int j = k; j < 4; j++) begin
        if (r_shadow[j] != 5'd0) begin
          w_blank[k] = 1'b0;
        end
      end
    end
  end

  assign w_code = w_blank[r_idx] ? CODE_BLANK : r_shadow[r_idx];

  seg7_decode u_decode (
    .code (w_code),
    .seg  (w_seg)
  );

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
      for (int k = 0; k < 4; k++) begin
        r_shadow[k] <= 5'd0;
      end
    end else begin
      if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Capture only at the frame boundary so a frame never mixes old and new digits
      if (w_frame_end) begin
        for (int k = 0; k < 4; k++) begin
          r_shadow[k] <= w_bcd[k];
        end
      end
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_an     <= 4'b1111;
      r_seg    <= SEG_BLANK;
      r_dp     <= 1'b1;
      r_si_led <= 1'b0;
    end else begin
      r_si_led <= si;
      if (r_cnt < CNT_BLANK) begin
        r_an  <= 4'b1111;
        r_seg <= SEG_BLANK;
        r_dp  <= 1'b1;
      end else begin
        r_an  <= ~(4'b0001 << r_idx);
        r_seg <= w_seg;
        r_dp  <= ~((r_idx == 2'd0) && r_si_led);
      end
    end
  end

  assign an     = r_an;
  assign seg    = r_seg;
  assign dp     = r_dp;
  assign si_led = r_si_led;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed digit patterns plus randomized input
// activity, compared every cycle against a time-indexed reference model.
module tb_seg7_scan_driver;

  localparam int DIV   = 8;
  localparam int BLK   = 2;
  localparam int FRAME = 4 * DIV;

  logic       sys_clk = 1'b0;
  logic       reset   = 1'b1;
  logic [4:0] bcd3 = '0, bcd2 = '0, bcd1 = '0, bcd0 = '0;
  logic       si = 1'b0, blz_en = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, si_led;

  seg7_scan_driver #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLK)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bcd3    (bcd3),
    .bcd2    (bcd2),
    .bcd1    (bcd1),
    .bcd0    (bcd0),
    .si      (si),
    .blz_en  (blz_en),
    .an      (an),
    .seg     (seg),
    .dp      (dp),
    .si_led  (si_led)
  );

  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;

  // Model state: edges since reset release, digits on display this frame, last sampled si
  int         m_k;
  logic [4:0] m_sh [4];
  logic       m_si;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s observed=%h required=%h edge=%0d", tag, obs, exp, m_k);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [4:0] c);
    case (c)
      5'd0: return 7'b1000000;
      5'd1: return 7'b1111001;
      5'd2: return 7'b0100100;
      5'd3: return 7'b0110000;
      5'd4: return 7'b0011001;
      5'd5: return 7'b0010010;
      5'd6: return 7'b0000010;
      5'd7: return 7'b1111000;
      5'd8: return 7'b0000000;
      5'd9: return 7'b0010000;
      5'h1F: return 7'b1110111;
      5'h10: return 7'h7F;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic model_reset();
    m_k  = 0;
    m_si = 1'b0;
    for (int j = 0; j < 4; j++) m_sh[j] = 5'd0;
  endtask

  // One clock: predict the registered outputs of the coming edge from the
  // position in the frame, let the edge happen, compare, return at negedge.
  task automatic cycle();
    int         phase, idx;
    bit         blank;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_si_led;
    phase = m_k % DIV;
    idx   = (m_k / DIV) % 4;
    e_an = 4'b1111; e_seg = 7'h7F; e_dp = 1'b1;
    if (phase >= BLK) begin
      e_an[idx] = 1'b0;
      blank = (blz_en == 1'b1) && (idx > 0);
      for (int j = idx; j < 4; j++)
        if (m_sh[j] != 5'd0) blank = 0;
      e_seg = blank ? 7'h7F : glyph(m_sh[idx]);
      e_dp  = !(idx == 0 && m_si);
    end
    e_si_led = si;
    if (m_k % FRAME == FRAME - 1) begin
      m_sh[3] = bcd3; m_sh[2] = bcd2; m_sh[1] = bcd1; m_sh[0] = bcd0;
    end
    m_si = si;
    @(posedge sys_clk);
    #1;
    check_val("an", 32'(an), 32'(e_an));
    check_val("seg", 32'(seg), 32'(e_seg));
    check_val("dp", 32'(dp), 32'(e_dp));
    check_val("si_led", 32'(si_led), 32'(e_si_led));
    m_k++;
    @(negedge sys_clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_to(input int pos);
    int guard = 0;
    while ((m_k % FRAME) != pos && guard < 2 * FRAME) begin
      cycle();
      guard++;
    end
    if ((m_k % FRAME) != pos) check_val("run_to_timeout", 32'(m_k % FRAME), 32'(pos));
  endtask

  task automatic set_bcd(input logic [4:0] a3, a2, a1, a0);
    bcd3 = a3; bcd2 = a2; bcd1 = a1; bcd0 = a0;
  endtask

  function automatic logic [4:0] rand_code();
    int r = $urandom_range(0, 9);
    if (r < 3) return 5'd0;
    if (r == 3) return 5'h1F;
    if (r == 4) return 5'h10;
    if (r == 5) return 5'($urandom);
    return 5'($urandom_range(0, 9));
  endfunction

  initial begin
    model_reset();
    repeat (3) @(negedge sys_clk);
    check_val("rst_an", 32'(an), 32'hF);
    check_val("rst_seg", 32'(seg), 32'h7F);
    check_val("rst_dp", 32'(dp), 32'h1);
    check_val("rst_si_led", 32'(si_led), 32'h0);
    reset = 1'b0;

    // First frame shows zeros, then 1,2,3,4
    set_bcd(5'd1, 5'd2, 5'd3, 5'd4);
    run(2 * FRAME);

    // Leading-zero blanking patterns
    blz_en = 1'b1;
    set_bcd(5'd0, 5'd0, 5'd0, 5'd7);      run(FRAME);
    set_bcd(5'd0, 5'd0, 5'd0, 5'd0);      run(FRAME);
    set_bcd(5'd0, 5'd0, 5'd5, 5'd0);      run(FRAME);
    set_bcd(5'd0, 5'd1, 5'h1F, 5'd5);     run(FRAME);
    set_bcd(5'd0, 5'd0, 5'h1F, 5'h0C);    run(FRAME);
    set_bcd(5'd0, 5'h10, 5'd0, 5'd3);     run(FRAME);
    blz_en = 1'b0;                         run(FRAME);

    // Mid-frame change must not appear until the next frame
    set_bcd(5'd1, 5'd1, 5'd1, 5'd1);
    run_to(0);
    run_to(DIV);
    set_bcd(5'd2, 5'd2, 5'd2, 5'd2);
    run(FRAME + DIV);

    // Decimal point follows si_led in lit digit-0 slots
    si = 1'b1; run(FRAME);
    si = 1'b0; run(FRAME);

    // Randomized activity
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 15) == 0) set_bcd(rand_code(), rand_code(), rand_code(), rand_code());
      if ($urandom_range(0, 63) == 0) blz_en = ~blz_en;
      if ($urandom_range(0, 7) == 0) si = 1'($urandom);
      cycle();
    end

    // Reset while digit 0 is lit: dark at once, scan restarts from idx 0
    set_bcd(5'd9, 5'd8, 5'd7, 5'd6);
    run_to(4);
    check_val("pre_rst_an", 32'(an), 32'hE);
    reset = 1'b1;
    #1;
    check_val("mid_rst_an", 32'(an), 32'hF);
    check_val("mid_rst_seg", 32'(seg), 32'h7F);
    check_val("mid_rst_dp", 32'(dp), 32'h1);
    @(posedge sys_clk);
    @(negedge sys_clk);
    reset = 1'b0;
    model_reset();
    si = 1'b1;
    run(2 * FRAME + 5);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) set_bcd(rand_code(), rand_code(), rand_code(), rand_code());
      if ($urandom_range(0, 31) == 0) blz_en = ~blz_en;
      if ($urandom_range(0, 3) == 0) si = 1'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
